// File: rtl/cacheline_arbiter.sv
// Two-port pmem arbiter: lets the icache and dcache share one cacheline port,
// one whole line transaction at a time, with round-robin or dcache-first ties.
`timescale 1ns/1ps

module cacheline_arbiter #(
    parameter int s_line        = 256,
    parameter bit PRIORITY_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [31:0]       i_pmem_address,
    input  logic              i_pmem_read,
    output logic [s_line-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic [31:0]       d_pmem_address,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic [31:0]       pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    typedef enum logic {ICACHE, DCACHE} side_t;

    state_t state, next_state;
    side_t  last_grant;
    logic   i_req, d_req;
    logic   grant_i, grant_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        i_req      = i_pmem_read;
        d_req      = d_pmem_read | d_pmem_write;
        case (state)
            IDLE: begin
                // On a tie the dcache wins if it has priority or the icache went last.
                grant_d = d_req && (!i_req || PRIORITY_MODE || last_grant == ICACHE);
                grant_i = i_req && !grant_d;
                if (grant_d)      next_state = SERVE_D;
                else if (grant_i) next_state = SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state        <= IDLE;
            last_grant   <= ICACHE;
            pmem_address <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_wdata   <= '0;
        end else begin
            state <= next_state;
            if (grant_d) begin
                // A simultaneous read+write from the dcache is treated as a writeback.
                pmem_address <= d_pmem_address;
                pmem_write   <= d_pmem_write;
                pmem_read    <= d_pmem_read & ~d_pmem_write;
                pmem_wdata   <= d_pmem_wdata;
                last_grant   <= DCACHE;
            end else if (grant_i) begin
                pmem_address <= i_pmem_address;
                pmem_write   <= 1'b0;
                pmem_read    <= 1'b1;
                pmem_wdata   <= '0;
                last_grant   <= ICACHE;
            end else if (state != IDLE && pmem_resp) begin
                pmem_address <= '0;
                pmem_write   <= 1'b0;
                pmem_read    <= 1'b0;
                pmem_wdata   <= '0;
            end
        end
    end

    assign busy         = (state != IDLE);
    assign i_pmem_resp  = (state == SERVE_I) && pmem_resp;
    assign d_pmem_resp  = (state == SERVE_D) && pmem_resp;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule
